vector_xbar_pipe: RTL and testbench



---
 rtl/vector_xbar_pkg.sv | 25 ++
 rtl/vector_xbar_row.sv | 56 +++++
 rtl/vector_xbar_pipe.sv | 155 +++++++++++++++
 tb/tb_vector_xbar_pipe.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_xbar_pkg.sv
// -----------------------------------------------------------------------------
// vector_xbar_pkg
// Shared definitions for the pipelined vector crossbar.
//   XBAR_MODE_OR   : every selected input lane is OR-merged into the output.
//   XBAR_MODE_PRIO : the lowest-index selected input lane wins.
//   xbar_multi_hot : returns 1 when a routing row has more than one bit set.
// -----------------------------------------------------------------------------
package vector_xbar_pkg;

    localparam int XBAR_MODE_OR   = 0;
    localparam int XBAR_MODE_PRIO = 1;

    // Widest routing row the multi-hot helper accepts; narrower rows are
    // zero-extended by the caller.
    localparam int XBAR_MAX_LANES = 64;

    localparam logic [XBAR_MAX_LANES-1:0] XBAR_ONE = 64'd1;

    // Clearing the lowest set bit leaves something behind only when at least
    // two bits were set, which avoids a full popcount.
    function automatic logic xbar_multi_hot(input logic [XBAR_MAX_LANES-1:0] row);
        return ((row & (row - XBAR_ONE)) != 64'd0);
    endfunction

endpackage : vector_xbar_pkg

// File: rtl/vector_xbar_row.sv
// -----------------------------------------------------------------------------
// vector_xbar_row
// One output lane of the crossbar. Purely combinational.
// Ports:
//   row_i      : routing row, bit i selects input lane i
//   in_data_i  : all input lanes, lane i at [DW*i +: DW]
//   lane_o     : routed lane value (0 when the row is empty)
//   conflict_o : row has more than one bit set
// -----------------------------------------------------------------------------
module vector_xbar_row
    import vector_xbar_pkg::*;
#(
    parameter int N_IN = 16,
    parameter int DW   = 8,
    parameter int MODE = XBAR_MODE_OR
) (
    input  logic [N_IN-1:0]    row_i,
    input  logic [N_IN*DW-1:0] in_data_i,
    output logic [DW-1:0]      lane_o,
    output logic               conflict_o
);

    logic [DW-1:0]             lane_s;
    logic                      found_s;
    logic [XBAR_MAX_LANES-1:0] row_ext_s;

    // Lane select: OR-merge or first-hit from lane 0 upwards.
    always_comb begin
        lane_s  = {DW{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (row_i[i]) begin
                if (MODE == XBAR_MODE_OR) begin
                    lane_s = lane_s | in_data_i[DW*i +: DW];
                end else if (!found_s) begin
                    lane_s  = in_data_i[DW*i +: DW];
                    found_s = 1'b1;
                end else begin
                    lane_s = lane_s;
                end
            end else begin
                lane_s = lane_s;
            end
        end
    end

    // Conflict flag is mode-independent.
    always_comb begin
        row_ext_s           = {XBAR_MAX_LANES{1'b0}};
        row_ext_s[N_IN-1:0] = row_i;
    end

    assign lane_o     = lane_s;
    assign conflict_o = xbar_multi_hot(row_ext_s);

endmodule : vector_xbar_row

// File: rtl/vector_xbar_pipe.sv
// -----------------------------------------------------------------------------
// vector_xbar_pipe
// Pipelined N_IN -> N_OUT lane crossbar with a registered output stage and a
// double-buffered routing mask that only switches between packets.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   cfg_valid/cfg_ready     : handshake loading cfg_mask into the shadow mask
//   cfg_mask                : bit [N_IN*o+i] routes input lane i to output o
//   in_valid/in_ready       : input beat handshake
//   in_data, in_last        : input lanes and end-of-packet marker
//   out_valid/out_ready     : output beat handshake
//   out_data, out_last      : routed lanes and registered end-of-packet
//   out_conflict            : per-output flag, active row had >1 bit set
// -----------------------------------------------------------------------------
module vector_xbar_pipe
    import vector_xbar_pkg::*;
#(
    parameter int N_IN  = 16,
    parameter int N_OUT = 20,
    parameter int DW    = 8,
    parameter int MODE  = XBAR_MODE_OR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [N_OUT*N_IN-1:0] cfg_mask,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN*DW-1:0]    in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_OUT*DW-1:0]   out_data,
    output logic                  out_last,
    output logic [N_OUT-1:0]      out_conflict
);

    logic [N_OUT*N_IN-1:0] active_q,  active_d;
    logic [N_OUT*N_IN-1:0] shadow_q,  shadow_d;
    logic                  pending_q, pending_d;
    logic                  mid_pkt_q, mid_pkt_d;
    logic                  out_valid_q,    out_valid_d;
    logic [N_OUT*DW-1:0]   out_data_q,     out_data_d;
    logic                  out_last_q,     out_last_d;
    logic [N_OUT-1:0]      out_conflict_q, out_conflict_d;

    logic                  accept_s;
    logic                  load_s;
    logic                  commit_s;
    logic [N_OUT*DW-1:0]   routed_s;
    logic [N_OUT-1:0]      conflict_s;

    // The output register can take a new beat when empty or draining this cycle.
    assign in_ready  = !out_valid_q || out_ready;
    assign cfg_ready = !pending_q;

    // Handshake and commit decode. Commit happens either with the closing beat
    // of a packet or on an idle cycle outside any packet.
    always_comb begin
        accept_s = in_valid && in_ready;
        load_s   = cfg_valid && cfg_ready;
        commit_s = pending_q && ((accept_s && in_last) || (!mid_pkt_q && !accept_s));
    end

    // One routing row per output lane; routing always uses the active mask, so
    // the beat accepted in a commit cycle still sees the old configuration.
    for (genvar o = 0; o < N_OUT; o++) begin : g_row
        vector_xbar_row #(
            .N_IN (N_IN),
            .DW   (DW),
            .MODE (MODE)
        ) u_row (
            .row_i      (active_q[N_IN*o +: N_IN]),
            .in_data_i  (in_data),
            .lane_o     (routed_s[DW*o +: DW]),
            .conflict_o (conflict_s[o])
        );
    end

    // Shadow/active mask next state. Load needs !pending and commit needs
    // pending, so the two never coincide.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (load_s) begin
            shadow_d  = cfg_mask;
            pending_d = 1'b1;
        end else if (commit_s) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Packet tracking: open on a non-last beat, close on the last one.
    always_comb begin
        mid_pkt_d = mid_pkt_q;
        if (accept_s) begin
            mid_pkt_d = !in_last;
        end else begin
            mid_pkt_d = mid_pkt_q;
        end
    end

    // Output stage next state: capture on accept, drop valid once drained,
    // otherwise hold everything.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_last_d     = out_last_q;
        out_conflict_d = out_conflict_q;
        if (accept_s) begin
            out_valid_d    = 1'b1;
            out_data_d     = routed_s;
            out_last_d     = in_last;
            out_conflict_d = conflict_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; reset discards any pending configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q       <= {(N_OUT*N_IN){1'b0}};
            shadow_q       <= {(N_OUT*N_IN){1'b0}};
            pending_q      <= 1'b0;
            mid_pkt_q      <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= {(N_OUT*DW){1'b0}};
            out_last_q     <= 1'b0;
            out_conflict_q <= {N_OUT{1'b0}};
        end else begin
            active_q       <= active_d;
            shadow_q       <= shadow_d;
            pending_q      <= pending_d;
            mid_pkt_q      <= mid_pkt_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_last_q     <= out_last_d;
            out_conflict_q <= out_conflict_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_last     = out_last_q;
    assign out_conflict = out_conflict_q;

endmodule : vector_xbar_pipe

// File: tb/tb_vector_xbar_pipe.sv
// -----------------------------------------------------------------------------
// tb_vector_xbar_pipe
// Scoreboard bench: two crossbar instances (OR-merge and priority) share all
// stimulus; expected beats are queued at acceptance and popped by monitors.
// -----------------------------------------------------------------------------
module tb_vector_xbar_pipe;

    localparam int NI = 16;
    localparam int NO = 20;
    localparam int W  = 8;

    typedef struct {
        logic [NO*W-1:0] data;
        logic            last;
        logic [NO-1:0]   conf;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_valid;
    logic [NO*NI-1:0]  cfg_mask;
    logic              in_valid;
    logic [NI*W-1:0]   in_data;
    logic              in_last;
    logic              out_ready;

    logic              cfg_ready0, in_ready0, out_valid0, out_last0;
    logic [NO*W-1:0]   out_data0;
    logic [NO-1:0]     out_conflict0;
    logic              cfg_ready1, in_ready1, out_valid1, out_last1;
    logic [NO*W-1:0]   out_data1;
    logic [NO-1:0]     out_conflict1;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t q0[$];
    exp_t q1[$];

    vector_xbar_pipe #(.N_IN(NI), .N_OUT(NO), .DW(W), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready0), .cfg_mask(cfg_mask),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_last(out_last0), .out_conflict(out_conflict0)
    );

    vector_xbar_pipe #(.N_IN(NI), .N_OUT(NO), .DW(W), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready1), .cfg_mask(cfg_mask),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_last(out_last1), .out_conflict(out_conflict1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [NO*W-1:0] act, input logic [NO*W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Reference: scan lanes high to low so the lowest selected lane is the
    // final write in priority mode; conflict from an explicit bit count.
    function automatic exp_t model(input logic [NI*W-1:0] d, input logic last,
                                   input logic [NO*NI-1:0] m, input int mode);
        exp_t e;
        int cnt;
        logic [W-1:0] lane;
        e.data = '0;
        e.last = last;
        e.conf = '0;
        for (int o = 0; o < NO; o++) begin
            lane = 8'h00;
            cnt  = 0;
            for (int i = NI - 1; i >= 0; i--) begin
                if (m[NI*o+i]) begin
                    cnt++;
                    if (mode == 0) lane = lane | d[W*i +: W];
                    else           lane = d[W*i +: W];
                end
            end
            e.data[W*o +: W] = lane;
            e.conf[o]        = (cnt > 1);
        end
        return e;
    endfunction

    function automatic logic [NI*W-1:0] mk(input logic [7:0] base);
        logic [NI*W-1:0] d;
        for (int i = 0; i < NI; i++) d[W*i +: W] = base + 8'(i) * 8'd17;
        return d;
    endfunction

    function automatic logic [NO*NI-1:0] ident_mask();
        logic [NO*NI-1:0] m;
        m = '0;
        for (int o = 0; o < NI; o++) m[NI*o+o] = 1'b1;
        return m;
    endfunction

    function automatic logic [NO*NI-1:0] rev_mask();
        logic [NO*NI-1:0] m;
        m = '0;
        for (int o = 0; o < NI; o++) m[NI*o+(NI-1-o)] = 1'b1;
        m[NI*19 +: NI] = 16'hFFFF;
        return m;
    endfunction

    task automatic push(input logic [NI*W-1:0] d, input logic last, input logic [NO*NI-1:0] m);
        q0.push_back(model(d, last, m, 0));
        q1.push_back(model(d, last, m, 1));
    endtask

    // Offer one beat (called at posedge+1); the mask argument is the routing
    // the bench expects to be active for it.
    task automatic send(input logic [NI*W-1:0] d, input logic last, input logic [NO*NI-1:0] m);
        logic acc;
        int n;
        acc = 1'b0;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = in_ready0;
            n++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no accept in %0d cycles required accept", n);
        end else begin
            push(d, last, m);
            chk("latency_valid", {159'd0, out_valid0}, {159'd0, 1'b1});
        end
    endtask

    task automatic load_idle(input logic [NO*NI-1:0] m);
        int n;
        n = 0;
        cfg_valid = 1'b1;
        cfg_mask  = m;
        do begin
            @(negedge clk);
            n++;
        end while (!cfg_ready0 && n < 20);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        chk("cfg_pending", {159'd0, cfg_ready0}, 160'd0);
        @(posedge clk);
        #1;
        chk("idle_commit", {159'd0, cfg_ready0}, {159'd0, 1'b1});
    endtask

    // Scoreboard monitor, OR-merge instance.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (rst_n && out_valid0 && out_ready) begin
            if (q0.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mon0_unexpected: got beat %h required none", out_data0);
            end else begin
                e = q0.pop_front();
                chk("mon0_data", out_data0, e.data);
                chk("mon0_last", {159'd0, out_last0}, {159'd0, e.last});
                chk("mon0_conf", {140'd0, out_conflict0}, {140'd0, e.conf});
            end
        end
    end

    // Scoreboard monitor, priority instance.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst_n && out_valid1 && out_ready) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mon1_unexpected: got beat %h required none", out_data1);
            end else begin
                e = q1.pop_front();
                chk("mon1_data", out_data1, e.data);
                chk("mon1_last", {159'd0, out_last1}, {159'd0, e.last});
                chk("mon1_conf", {140'd0, out_conflict1}, {140'd0, e.conf});
            end
        end
    end

    initial begin : stim
        logic [NO*NI-1:0] m_id, m_merge, m_rev;
        logic [NI*W-1:0]  d, capture_in;
        logic [NO*W-1:0]  capture;
        m_id    = ident_mask();
        m_merge = m_id;
        m_merge[NI*3 +: NI] = 16'h0006;
        m_rev   = rev_mask();

        rst_n = 1'b0; cfg_valid = 1'b0; cfg_mask = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {159'd0, out_valid0}, 160'd0);
        chk("rst_out_data", out_data0, 160'd0);
        chk("rst_out_last", {159'd0, out_last0}, 160'd0);
        chk("rst_out_conf", {140'd0, out_conflict0}, 160'd0);
        chk("rst_cfg_ready", {159'd0, cfg_ready0}, {159'd0, 1'b1});
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Identity routing, 4-beat packet streamed back to back.
        load_idle(m_id);
        d = mk(8'h10);
        send(d, 1'b0, m_id);
        chk("ident_lanes", {32'd0, out_data0[NI*W-1:0]}, {32'd0, d});
        chk("ident_upper", {128'd0, out_data0[NO*W-1:NI*W]}, 160'd0);
        send(mk(8'h23), 1'b0, m_id);
        send(mk(8'h5A), 1'b0, m_id);
        send(mk(8'hC1), 1'b1, m_id);

        // Broadcast plus merge on row 3.
        load_idle(m_merge);
        d = mk(8'h00);
        d[W*1 +: W] = 8'h0F;
        d[W*2 +: W] = 8'hF0;
        send(d, 1'b1, m_merge);
        chk("merge_or_lane3", {152'd0, out_data0[W*3 +: W]}, {152'd0, 8'hFF});
        chk("merge_prio_lane3", {152'd0, out_data1[W*3 +: W]}, {152'd0, 8'h0F});
        chk("merge_conf3", {159'd0, out_conflict0[3]}, {159'd0, 1'b1});
        chk("merge_conf3_prio", {159'd0, out_conflict1[3]}, {159'd0, 1'b1});

        // Reconfigure during beat 2 of a 5-beat packet.
        send(mk(8'h31), 1'b0, m_merge);
        cfg_valid = 1'b1;
        cfg_mask  = m_rev;
        send(mk(8'h42), 1'b0, m_merge);
        cfg_valid = 1'b0;
        chk("mid_cfg_ready_b2", {159'd0, cfg_ready0}, 160'd0);
        send(mk(8'h53), 1'b0, m_merge);
        chk("mid_cfg_ready_b3", {159'd0, cfg_ready0}, 160'd0);
        send(mk(8'h64), 1'b0, m_merge);
        chk("mid_cfg_ready_b4", {159'd0, cfg_ready0}, 160'd0);
        send(mk(8'h75), 1'b1, m_merge);
        chk("mid_cfg_ready_after", {159'd0, cfg_ready0}, {159'd0, 1'b1});
        send(mk(8'h86), 1'b0, m_rev);

        // Backpressure: held output, blocked input for three cycles.
        out_ready  = 1'b0;
        capture    = out_data0;
        capture_in = mk(8'h97);
        in_valid   = 1'b1;
        in_data    = capture_in;
        in_last    = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", {159'd0, in_ready0}, 160'd0);
            chk("bp_hold", out_data0, capture);
            chk("bp_valid", {159'd0, out_valid0}, {159'd0, 1'b1});
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {159'd0, in_ready0}, {159'd0, 1'b1});
        @(posedge clk);
        #1;
        push(capture_in, 1'b1, m_rev);
        in_valid = 1'b0;

        // Reset with a packet open and a config pending.
        send(mk(8'hA8), 1'b0, m_rev);
        cfg_valid = 1'b1;
        cfg_mask  = m_id;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        chk("rst_pre_pending", {159'd0, cfg_ready0}, 160'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {159'd0, out_valid0}, 160'd0);
        chk("arst_out_data", out_data0, 160'd0);
        chk("arst_out_last", {159'd0, out_last0}, 160'd0);
        chk("arst_out_conf", {140'd0, out_conflict0}, 160'd0);
        chk("arst_cfg_ready", {159'd0, cfg_ready0}, {159'd0, 1'b1});
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(mk(8'hB9), 1'b0, '0);
        chk("post_rst_zero", out_data0, 160'd0);
        send(mk(8'hCA), 1'b1, '0);

        repeat (3) @(posedge clk);
        #1;
        chk("q0_drained", 160'(q0.size()), 160'd0);
        chk("q1_drained", 160'(q1.size()), 160'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_vector_xbar_pipe
